// File: rtl/ddr3_tg_pkg.sv
// rtl/ddr3_tg_pkg.sv - shared state, pattern encodings and helpers for the DDR3 traffic generator
package ddr3_tg_pkg;

    typedef logic [2:0] tg_state_t;

    localparam tg_state_t ST_IDLE   = 3'd0;
    localparam tg_state_t ST_WRITE  = 3'd1;
    localparam tg_state_t ST_WDRAIN = 3'd2;
    localparam tg_state_t ST_READ   = 3'd3;
    localparam tg_state_t ST_RDRAIN = 3'd4;
    localparam tg_state_t ST_DONE   = 3'd5;

    localparam logic [1:0] PAT_ADDR     = 2'd0;
    localparam logic [1:0] PAT_WALK     = 2'd1;
    localparam logic [1:0] PAT_XORSHIFT = 2'd2;
    localparam logic [1:0] PAT_NADDR    = 2'd3;

    localparam logic [31:0] WORD_STRIDE = 32'd16;

    function automatic logic [31:0] xorshift32(input logic [31:0] x);
        logic [31:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

endpackage

// File: rtl/ddr3_tg_pattern.sv
// rtl/ddr3_tg_pattern.sv - combinational 128-bit data pattern for one word index
module ddr3_tg_pattern
    import ddr3_tg_pkg::*;
(
    input  logic [1:0]   pattern,
    input  logic [31:0]  seed,
    input  logic [15:0]  idx,
    input  logic [31:0]  base,
    output logic [127:0] data
);

    logic [31:0] addr;
    logic [31:0] w0, w1, w2, w3, w4;

    always_comb begin
        addr = base + ({16'd0, idx} * WORD_STRIDE);
        w0   = seed ^ {16'd0, idx};
        w1   = xorshift32(w0);
        w2   = xorshift32(w1);
        w3   = xorshift32(w2);
        w4   = xorshift32(w3);
        case (pattern)
            PAT_ADDR:     data = {4{addr}};
            PAT_WALK:     data = 128'd1 << idx[6:0];
            PAT_XORSHIFT: data = {w4, w3, w2, w1};
            default:      data = ~{4{addr}};
        endcase
    end

endmodule

// File: rtl/ddr3_traffic_gen.sv
// rtl/ddr3_traffic_gen.sv - write-then-readback memory traffic generator with checker
// Optional: define DDR3_TG_PERF_EN to add perf_cycles_o (start-to-done cycle count).
module ddr3_traffic_gen
    import ddr3_tg_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE       = 32'h0,
    parameter int          NUM_WORDS       = 16,
    parameter int          MAX_OUTSTANDING = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         start_i,
    input  logic [1:0]   pattern_i,
    input  logic [31:0]  seed_i,
    output logic [15:0]  outport_wr_o,
    output logic         outport_rd_o,
    output logic [31:0]  outport_addr_o,
    output logic [127:0] outport_write_data_o,
    output logic [15:0]  outport_req_id_o,
    input  logic         outport_accept_i,
    input  logic         outport_ack_i,
    input  logic         outport_error_i,
    input  logic [15:0]  outport_resp_id_i,
    input  logic [127:0] outport_read_data_i,
`ifdef DDR3_TG_PERF_EN
    output logic [31:0]  perf_cycles_o,
`endif
    output logic         busy_o,
    output logic         done_o,
    output logic         pass_o,
    output logic [15:0]  err_count_o,
    output logic [15:0]  first_err_idx_o
);

    localparam logic [15:0] LAST_IDX = 16'(NUM_WORDS - 1);
    localparam logic [3:0]  MAX_OUT  = 4'(MAX_OUTSTANDING);

    tg_state_t   state;
    logic [15:0] idx;
    logic [3:0]  outstanding;
    logic [3:0]  outstanding_next;
    logic [1:0]  pattern_q;
    logic [31:0] seed_q;
    logic [15:0] err_count;
    logic [15:0] first_err_idx;

    logic         issuing;
    logic         accepted;
    logic         ack_valid;
    logic         resp_bad;
    logic         write_phase;
    logic [127:0] issue_data;
    logic [127:0] check_data;

    ddr3_tg_pattern u_issue_pattern (
        .pattern (pattern_q),
        .seed    (seed_q),
        .idx     (idx),
        .base    (ADDR_BASE),
        .data    (issue_data)
    );

    ddr3_tg_pattern u_check_pattern (
        .pattern (pattern_q),
        .seed    (seed_q),
        .idx     (outport_resp_id_i),
        .base    (ADDR_BASE),
        .data    (check_data)
    );

    // The request is a pure function of registered state, so it cannot change
    // while stalled: outstanding can only fall until this request is accepted.
    assign issuing     = ((state == ST_WRITE) || (state == ST_READ)) && (outstanding < MAX_OUT);
    assign accepted    = issuing && outport_accept_i;
    assign ack_valid   = outport_ack_i && (outstanding != 4'd0);
    assign write_phase = (state == ST_WRITE) || (state == ST_WDRAIN);
    assign resp_bad    = outport_error_i || (!write_phase && (outport_read_data_i != check_data));

    always_comb begin
        outstanding_next = outstanding;
        case ({accepted, ack_valid})
            2'b10:   outstanding_next = outstanding + 4'd1;
            2'b01:   outstanding_next = outstanding - 4'd1;
            default: outstanding_next = outstanding;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= ST_IDLE;
            idx           <= 16'd0;
            outstanding   <= 4'd0;
            pattern_q     <= 2'd0;
            seed_q        <= 32'd0;
            err_count     <= 16'd0;
            first_err_idx <= 16'd0;
        end else begin
            outstanding <= outstanding_next;
            if (ack_valid && resp_bad) begin
                if (err_count != 16'hFFFF) begin
                    err_count <= err_count + 16'd1;
                end
                if (err_count == 16'd0) begin
                    first_err_idx <= outport_resp_id_i;
                end
            end
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        state         <= ST_WRITE;
                        idx           <= 16'd0;
                        err_count     <= 16'd0;
                        first_err_idx <= 16'd0;
                        pattern_q     <= pattern_i;
                        seed_q        <= seed_i;
                    end
                end
                ST_WRITE, ST_READ: begin
                    if (accepted) begin
                        if (idx == LAST_IDX) begin
                            state <= (state == ST_WRITE) ? ST_WDRAIN : ST_RDRAIN;
                            idx   <= 16'd0;
                        end else begin
                            idx <= idx + 16'd1;
                        end
                    end
                end
                ST_WDRAIN: begin
                    if (outstanding == 4'd0) begin
                        state <= ST_READ;
                    end
                end
                ST_RDRAIN: begin
                    if (outstanding == 4'd0) begin
                        state <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef DDR3_TG_PERF_EN
    logic [31:0] perf_cycles;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_cycles <= 32'd0;
        end else if (((state == ST_IDLE) || (state == ST_DONE)) && start_i) begin
            perf_cycles <= 32'd0;
        end else if (busy_o && (perf_cycles != 32'hFFFF_FFFF)) begin
            perf_cycles <= perf_cycles + 32'd1;
        end
    end

    assign perf_cycles_o = perf_cycles;
`endif

    assign outport_wr_o         = (issuing && (state == ST_WRITE)) ? 16'hFFFF : 16'h0000;
    assign outport_rd_o         = issuing && (state == ST_READ);
    assign outport_addr_o       = issuing ? (ADDR_BASE + ({16'd0, idx} * WORD_STRIDE)) : 32'd0;
    assign outport_write_data_o = (issuing && (state == ST_WRITE)) ? issue_data : 128'd0;
    assign outport_req_id_o     = issuing ? idx : 16'd0;

    assign busy_o          = (state == ST_WRITE) || (state == ST_WDRAIN) ||
                             (state == ST_READ)  || (state == ST_RDRAIN);
    assign done_o          = (state == ST_DONE);
    assign pass_o          = (state == ST_DONE) && (err_count == 16'd0);
    assign err_count_o     = err_count;
    assign first_err_idx_o = first_err_idx;

endmodule
